// File: rtl/aqalu_pkg.sv
// Shared definitions for the 2-bit ALU op sequencer: opcodes, entry layout, FSM states.
package aqalu_pkg;

  localparam logic [3:0] OP_AND  = 4'd0;
  localparam logic [3:0] OP_ADD  = 4'd7;
  localparam logic [3:0] OP_MUL  = 4'd9;
  localparam logic [3:0] OP_CMP  = 4'd10;
  localparam logic [3:0] OP_RSUM = 4'd15;

  localparam int ENTRY_OP_LSB = 4;
  localparam int ENTRY_A_LSB  = 2;
  localparam int ENTRY_B_LSB  = 0;

  // One program step: {opcode[7:4], A[3:2], B[1:0]}
  typedef struct packed {
    logic [3:0] opcode;
    logic [1:0] a;
    logic [1:0] b;
  } entry_t;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_ISSUE     = 3'd1,
    S_SETTLE    = 3'd2,
    S_CAPTURE   = 3'd3,
    S_WAIT_TICK = 3'd4,
    S_FINISH    = 3'd5
  } seq_state_t;

endpackage

// File: rtl/aqalu_tick_div.sv
// Interval counter: counts up from zero while enabled, flags the terminal count.
module aqalu_tick_div #(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic             enable,
  input  logic [WIDTH-1:0] last,
  output logic             tc
);

  logic [WIDTH-1:0] count;

  // Count register; clear restarts the interval at zero.
  always_ff @(posedge clock) begin
    if (reset || clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + WIDTH'(1);
    end
  end

  assign tc = (count == last);

endmodule

// File: rtl/aqalu_op_sequencer.sv
// Steps through a small {opcode, A, B} program, drives the ALU, and reports each result.
//
// state     | meaning
// ----------+------------------------------------------------
// IDLE      | waiting; program writes and start accepted here
// ISSUE     | load ALU inputs from mem[idx]
// SETTLE    | hold ALU inputs for SETTLE_CYCLES
// CAPTURE   | register ALU output and step index
// WAIT_TICK | pacing gap of TICK_DIV cycles before next step
// FINISH    | run complete; done strobes next cycle
module aqalu_op_sequencer
  import aqalu_pkg::*;
#(
  parameter int TICK_DIV      = 50_000_000,
  parameter int SETTLE_CYCLES = 2,
  parameter int ADDR_W        = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              prog_we,
  input  logic [ADDR_W-1:0] prog_addr,
  input  logic [7:0]        prog_data,
  input  logic [ADDR_W:0]   run_len,
  input  logic              start,
  input  logic              abort,
  output logic [3:0]        alu_opcode,
  output logic [1:0]        alu_a,
  output logic [1:0]        alu_b,
  input  logic [7:0]        alu_result,
  output logic              result_valid,
  output logic [7:0]        result_data,
  output logic [ADDR_W-1:0] result_index,
  output logic              busy,
  output logic              done
);

  localparam int DEPTH    = 2 ** ADDR_W;
  localparam int TICK_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int SETTLE_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  seq_state_t        state, next_state;
  entry_t            mem [DEPTH];
  logic [ADDR_W-1:0] idx;
  logic [ADDR_W:0]   len_q;
  logic [ADDR_W:0]   len_eff;
  logic              last_step;
  logic              settle_tc, tick_tc;
  logic              settle_clear, settle_en, tick_clear, tick_en;

  // Oversized run lengths are limited to the program depth so idx never wraps.
  assign len_eff   = (run_len > (ADDR_W+1)'(DEPTH)) ? (ADDR_W+1)'(DEPTH) : run_len;
  assign last_step = ({1'b0, idx} == (len_q - (ADDR_W+1)'(1)));

  assign settle_clear = (state == S_ISSUE);
  assign settle_en    = (state == S_SETTLE);
  assign tick_clear   = (state == S_CAPTURE);
  assign tick_en      = (state == S_WAIT_TICK);

  aqalu_tick_div #(.WIDTH(SETTLE_W)) u_settle (
    .clock  (clock),
    .reset  (reset),
    .clear  (settle_clear),
    .enable (settle_en),
    .last   (SETTLE_W'(SETTLE_CYCLES - 1)),
    .tc     (settle_tc)
  );

  aqalu_tick_div #(.WIDTH(TICK_W)) u_tick (
    .clock  (clock),
    .reset  (reset),
    .clear  (tick_clear),
    .enable (tick_en),
    .last   (TICK_W'(TICK_DIV - 1)),
    .tc     (tick_tc)
  );

  // Program memory is deliberately not reset so a board reset keeps the loaded program.
  always_ff @(posedge clock) begin
    if (!reset && state == S_IDLE && prog_we) begin
      mem[prog_addr] <= entry_t'(prog_data);
    end
  end

  // Next-state selection; abort overrides every transition.
  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:      if (start) next_state = (run_len == '0) ? S_FINISH : S_ISSUE;
      S_ISSUE:     next_state = S_SETTLE;
      S_SETTLE:    if (settle_tc) next_state = S_CAPTURE;
      S_CAPTURE:   next_state = last_step ? S_FINISH : S_WAIT_TICK;
      S_WAIT_TICK: if (tick_tc) next_state = S_ISSUE;
      S_FINISH:    next_state = S_IDLE;
      default:     next_state = S_IDLE;
    endcase
    if (abort) next_state = S_IDLE;
  end

  // State register plus all registered outputs and run bookkeeping.
  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= S_IDLE;
      idx          <= '0;
      len_q        <= '0;
      alu_opcode   <= '0;
      alu_a        <= '0;
      alu_b        <= '0;
      result_valid <= 1'b0;
      result_data  <= '0;
      result_index <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else begin
      state        <= next_state;
      busy         <= (next_state != S_IDLE);
      result_valid <= (state == S_CAPTURE);
      done         <= (state == S_FINISH) && !abort;
      case (state)
        S_IDLE: begin
          if (start && !abort && run_len != '0) begin
            len_q <= len_eff;
            idx   <= '0;
          end
        end
        S_ISSUE: begin
          if (!abort) begin
            alu_opcode <= mem[idx].opcode;
            alu_a      <= mem[idx].a;
            alu_b      <= mem[idx].b;
          end
        end
        S_CAPTURE: begin
          result_data  <= alu_result;
          result_index <= idx;
        end
        S_WAIT_TICK: begin
          if (tick_tc && !abort) idx <= idx + ADDR_W'(1);
        end
        default: ;
      endcase
    end
  end

endmodule
